uart_tx: RTL

- 8N1 UART transmitter; the transmit-side counterpart of the team's 16x-oversampled UART receiver.
- Serialises bytes LSB-first onto an idle-high line, and shares the same external sample_tick (16 ticks per bit).
- Accepts bytes through a valid/ready handshake into a one-deep holding register, so back-to-back frames go out with no idle gap.
- Sits between the host/bus-side logic and the pad; the line output connects directly to the receiver's serial input.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_tx.sv | 123 ++++++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and receiver: frame geometry and
// the FSM state encoding that both sides use.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter driven by the shared OVERSAMPLE x baud sample_tick.
// A one-deep holding register behind valid/ready lets frames go out back-to-back.
module uart_tx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int STOP_BITS  = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sample_tick,
  input  logic                      tx_valid,
  input  logic [UART_DATA_BITS-1:0] tx_byte,
  output logic                      tx_ready,
  output logic                      tx_line,
  output logic                      tx_busy,
  output logic                      tx_done
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_MAX  = CW'(OVERSAMPLE - 1);
  localparam logic [2:0]    IDX_LAST = 3'(UART_DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  logic [1:0]                state;
  logic [CW-1:0]             tick_cnt;
  logic [2:0]                bit_idx;
  logic                      stop_cnt;
  logic [UART_DATA_BITS-1:0] shift;
  logic [UART_DATA_BITS-1:0] hold;
  logic                      end_bit;
  logic                      accept;

  // tx_ready doubles as the holding-register-empty flag.
  assign accept  = tx_valid && tx_ready;
  assign end_bit = sample_tick && (tick_cnt == CNT_MAX);
  assign tx_busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      tick_cnt <= '0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
      shift    <= '0;
      hold     <= '0;
      tx_ready <= 1'b1;
      tx_line  <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;

      // Accept needs an empty holding register, load needs a full one, so
      // the two writes to tx_ready below can never land on the same edge.
      if (accept) begin
        hold     <= tx_byte;
        tx_ready <= 1'b0;
      end

      if (sample_tick) begin
        case (state)
          ST_IDLE: begin
            if (!tx_ready) begin
              shift    <= hold;
              tx_ready <= 1'b1;
              tx_line  <= 1'b0;
              tick_cnt <= '0;
              state    <= ST_START;
            end
          end

          ST_START: begin
            tick_cnt <= tick_cnt + 1'b1;
            if (end_bit) begin
              tx_line <= shift[0];
              bit_idx <= '0;
              state   <= ST_DATA;
            end
          end

          ST_DATA: begin
            tick_cnt <= tick_cnt + 1'b1;
            if (end_bit) begin
              if (bit_idx != IDX_LAST) begin
                shift   <= shift >> 1;
                tx_line <= shift[1];
                bit_idx <= bit_idx + 1'b1;
              end else begin
                tx_line  <= 1'b1;
                stop_cnt <= 1'b0;
                state    <= ST_STOP;
              end
            end
          end

          ST_STOP: begin
            // Counter wraps to zero at end of bit, which is also where a
            // chained start bit must begin.
            tick_cnt <= tick_cnt + 1'b1;
            if (end_bit) begin
              if (stop_cnt == STOP_LAST) begin
                tx_done <= 1'b1;
                if (!tx_ready) begin
                  shift    <= hold;
                  tx_ready <= 1'b1;
                  tx_line  <= 1'b0;
                  state    <= ST_START;
                end else begin
                  state <= ST_IDLE;
                end
              end else begin
                stop_cnt <= 1'b1;
              end
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
